// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response and decode-side handshake bundle for fetch_queue.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic [XLEN-1:0] IR;
  logic [XLEN-1:0] IR_pc;
  logic            IR_valid;
  logic            IR_ready;

  modport master (
    output imem_req_valid, imem_addr, IR, IR_pc, IR_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, IR_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, IR, IR_pc, IR_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, IR_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, credit-limited in-order memory requests,
// DEPTH-entry instruction queue to decode, and conditional redirect with stale-response drop.
module fetch_queue #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_queue_if.master   bus,
  input  logic            redirect,
  input  logic [3:0]      redirect_cond,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [3:0]      NZCV,
  output logic            redirect_taken
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  entry_t           q_mem_q [DEPTH];
  entry_t           q_mem_d [DEPTH];
  logic [XLEN-1:0]  tag_q [DEPTH];
  logic [XLEN-1:0]  tag_d [DEPTH];

  logic cond_ok, credit, req_fire, rsp_fire, drop, push, pop;

  // Condition decode over {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    unique case (redirect_cond)
      4'd0:    cond_ok = 1'b1;
      4'd1:    cond_ok = NZCV[2];
      4'd2:    cond_ok = !NZCV[2];
      4'd3:    cond_ok = NZCV[1];
      4'd4:    cond_ok = !NZCV[1];
      4'd5:    cond_ok = NZCV[3];
      4'd6:    cond_ok = !NZCV[3];
      4'd7:    cond_ok = NZCV[0];
      4'd8:    cond_ok = !NZCV[0];
      default: cond_ok = 1'b0;
    endcase
  end

  assign redirect_taken = redirect && cond_ok;

  // Queued words plus in-flight requests never exceed DEPTH, so every response has a slot
  assign credit   = (SUM_W'(occ_q) + SUM_W'(out_cnt_q)) < SUM_W'(DEPTH);
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign drop     = rsp_fire && (drop_cnt_q != '0);
  assign push     = rsp_fire && !drop && !redirect_taken;
  assign pop      = (occ_q != '0) && bus.IR_ready;

  assign bus.imem_req_valid = rst && credit && !redirect_taken;
  assign bus.imem_addr      = pc_q;
  assign bus.IR             = q_mem_q[head_q].data;
  assign bus.IR_pc          = q_mem_q[head_q].pc;
  assign bus.IR_valid       = (occ_q != '0);

  always_comb begin
    pc_d       = pc_q;
    occ_d      = occ_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    q_mem_d    = q_mem_q;
    tag_d      = tag_q;

    if (req_fire) begin
      pc_d            = pc_q + XLEN'(PC_STEP);
      tag_d[tag_wr_q] = pc_q;
      tag_wr_d        = tag_wr_q + PTR_W'(1);
    end
    // Tag FIFO pops on every response, stale or not, to stay aligned with memory order
    if (rsp_fire) begin
      tag_rd_d = tag_rd_q + PTR_W'(1);
    end
    if (push) begin
      q_mem_d[tail_q].data = bus.imem_rsp_data;
      q_mem_d[tail_q].pc   = tag_q[tag_rd_q];
      tail_d               = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end

    out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    occ_d     = occ_q + CNT_W'(push) - CNT_W'(pop);

    // Everything still in flight after this cycle belongs to the old path
    if (redirect_taken) begin
      pc_d       = redirect_target;
      occ_d      = '0;
      head_d     = tail_q;
      drop_cnt_d = out_cnt_q - CNT_W'(rsp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      occ_q      <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      q_mem_q    <= '{default: '0};
      tag_q      <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      occ_q      <= occ_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      q_mem_q    <= q_mem_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency and a
// stream-level reference (next expected decode PC, next request PC, credit accounting).
module tb_fetch_queue;

  localparam int unsigned    XLEN     = 32;
  localparam int unsigned    DEPTH    = 4;
  localparam logic [31:0]    RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [3:0]  redirect_cond;
  logic [31:0] redirect_target;
  logic [3:0]  NZCV;
  logic        redirect_taken;

  fetch_queue_if #(.XLEN(XLEN)) bus ();

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .redirect(redirect), .redirect_cond(redirect_cond),
    .redirect_target(redirect_target), .NZCV(NZCV),
    .redirect_taken(redirect_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: stream positions and word accounting
  int          m_occ, m_out, m_drop;
  logic [31:0] exp_pc, exp_req;
  int          cyc;
  int          lat_min, lat_max;
  int          last_due;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          dut_pops;

  // Values sampled by the most recent step
  logic        s_taken, s_req_valid, s_ir_valid;
  logic [31:0] s_addr, s_ir_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return ~z;
      4'd3: return cf;
      4'd4: return ~cf;
      4'd5: return n;
      4'd6: return ~n;
      4'd7: return v;
      4'd8: return ~v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_occ = 0; m_out = 0; m_drop = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    pend_addr.delete(); pend_due.delete();
    last_due = cyc;
  endtask

  // One clock cycle: drive at negedge, check combinational/registered outputs, advance model
  task automatic step(input logic redir, input logic [3:0] cond, input logic [3:0] nzcv,
                      input logic [31:0] tgt, input logic irr, input logic mrdy);
    logic taken, exp_rv, rsp, pop;
    int due;
    @(negedge clk);
    rst = 1'b1;
    redirect = redir; redirect_cond = cond; NZCV = nzcv; redirect_target = tgt;
    bus.IR_ready = irr; bus.imem_req_ready = mrdy;
    rsp = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      rsp = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    s_taken = redirect_taken; s_req_valid = bus.imem_req_valid; s_ir_valid = bus.IR_valid;
    s_addr = bus.imem_addr; s_ir_pc = bus.IR_pc;

    taken  = redir && cond_true(cond, nzcv);
    exp_rv = (m_occ + m_out < DEPTH) && !taken;
    chk("redirect_taken", 32'(redirect_taken), 32'(taken));
    chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    chk("imem_addr", bus.imem_addr, exp_req);
    chk("IR_valid", 32'(bus.IR_valid), 32'(m_occ > 0));
    if (m_occ > 0) begin
      chk("IR_pc", bus.IR_pc, exp_pc);
      chk("IR", bus.IR, mem_word(exp_pc));
    end
    if (bus.IR_valid && irr) dut_pops++;

    if (bus.imem_req_valid && mrdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(due);
    end
    pop = (m_occ > 0) && irr;
    if (exp_rv && mrdy) begin m_out++; exp_req = exp_req + 32'd4; end
    if (pop) begin m_occ--; exp_pc = exp_pc + 32'd4; end
    if (rsp) begin
      m_out--;
      if (m_drop > 0) m_drop--;
      else if (!taken) m_occ++;
    end
    if (taken) begin
      exp_req = tgt; exp_pc = tgt; m_occ = 0; m_drop = m_out;
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic irr);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 32'h0, irr, 1'b1);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_IR_valid", 32'(bus.IR_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_IR", bus.IR, 32'h0);
    chk("rst_IR_pc", bus.IR_pc, 32'h0);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    cyc = 0; lat_min = 1; lat_max = 1; dut_pops = 0;
    rst = 1'b0;
    redirect = 1'b0; redirect_cond = 4'd0; redirect_target = '0; NZCV = 4'd0;
    bus.IR_ready = 1'b0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    model_reset();
    #3;
    chk("reset_IR_valid", 32'(bus.IR_valid), 32'd0);
    chk("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("reset_addr", bus.imem_addr, RESET_PC);
    chk("reset_IR", bus.IR, 32'h0);
    chk("reset_IR_pc", bus.IR_pc, 32'h0);

    // Free run, zero-wait memory
    run(20, 1'b1);
    chk("free_run_pops", 32'(dut_pops), 32'd18);

    // Decode stall: queue fills to DEPTH and requests stop
    run(10, 1'b0);
    chk("stall_full_valid", 32'(s_ir_valid), 32'd1);
    chk("stall_no_req", 32'(s_req_valid), 32'd0);
    run(8, 1'b1);

    // Three-cycle memory, redirect with three requests outstanding
    lat_min = 3; lat_max = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1);
      if (m_out == 3) got = 1'b1;
    end
    chk("out3_reached", 32'(got), 32'd1);
    step(1'b1, 4'd0, 4'd0, 32'h100, 1'b1, 1'b1);
    chk("redir_taken_cond0", 32'(s_taken), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1);
      if (s_ir_valid) got = 1'b1;
    end
    chk("redir_no_timeout", 32'(got), 32'd1);
    chk("redir_first_pc", s_ir_pc, 32'h100);
    lat_min = 1; lat_max = 1;
    run(6, 1'b1);

    // Condition evaluation
    step(1'b1, 4'd1, 4'b0000, 32'h200, 1'b1, 1'b1);
    chk("cond1_z0", 32'(s_taken), 32'd0);
    run(3, 1'b1);
    step(1'b1, 4'd1, 4'b0100, 32'h200, 1'b1, 1'b1);
    chk("cond1_z1", 32'(s_taken), 32'd1);
    run(3, 1'b1);
    step(1'b1, 4'd12, 4'b1111, 32'h300, 1'b1, 1'b1);
    chk("cond12_never", 32'(s_taken), 32'd0);
    run(3, 1'b1);

    // PC wrap at top of address space
    step(1'b1, 4'd0, 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr_zero", s_addr, 32'h0000_0000);
    run(6, 1'b1);

    // Randomised traffic: variable latency, backpressure, redirects
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), 4'($urandom),
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    // Reset with the queue full, then restart from RESET_PC
    lat_min = 1; lat_max = 1;
    run(12, 1'b0);
    chk("pre_rst_full", 32'(s_ir_valid), 32'd1);
    mid_reset();
    run(10, 1'b1);
    chk("post_rst_stream", s_ir_pc, 32'd28);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
